// File: rtl/icache_refill_ctrl_pkg.sv
// Shared state encoding and width helpers for the instruction-cache refill path.
package icache_refill_ctrl_pkg;

   localparam int WORD_BITS_DEF       = 32;
   localparam int BLOCK_WORDS_DEF     = 4;
   localparam int BLOCK_ADDR_BITS_DEF = 8;

   localparam logic [15:0] MISS_COUNT_MAX = 16'hFFFF;

   // Refill controller states; encoding matches the cache constants file.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_FILL   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_REPLAY = 3'd4
   } refill_state_t;

   function automatic int block_bits(input int word_bits, input int block_words);
      return word_bits * block_words;
   endfunction

   function automatic int off_bits(input int block_words);
      return $clog2(block_words);
   endfunction

   // Miss counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == MISS_COUNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/icache_fill_buffer.sv
// Beat counter plus word-indexed block register that assembles one cache block
// from in-order memory beats (word 0 lands in the least significant bits).
module icache_fill_buffer
   import icache_refill_ctrl_pkg::*;
#(
   parameter int WORD_BITS   = WORD_BITS_DEF,
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
   parameter int OFF_BITS    = off_bits(BLOCK_WORDS),
   localparam int BLOCK_BITS = block_bits(WORD_BITS, BLOCK_WORDS)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  rvalid,
   input  logic [WORD_BITS-1:0]  rdata,
   output logic [BLOCK_BITS-1:0] block,
   output logic                  last_beat
);

   localparam logic [OFF_BITS-1:0] LAST_IDX = OFF_BITS'(BLOCK_WORDS - 1);

   logic [OFF_BITS-1:0] cnt;

   assign last_beat = rvalid && (cnt == LAST_IDX);

   // Store each beat into its word slot and advance the counter; it wraps to 0 after the last word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the block register is reset too, so the fill port never shows stale or X data after reset.
         cnt   <= '0;
         block <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (rvalid) begin
         // NOTE: non-blocking assignments so the slot index uses this cycle's cnt, not the incremented one.
         block[int'(cnt)*WORD_BITS +: WORD_BITS] <= rdata;
         cnt <= cnt + OFF_BITS'(1);
      end
   end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: serves hits combinationally, refills missing
// blocks from instruction memory, writes them into the SRAM and replays the lookup.
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int WORD_BITS       = WORD_BITS_DEF,
   parameter int BLOCK_WORDS     = BLOCK_WORDS_DEF,
   parameter int BLOCK_ADDR_BITS = BLOCK_ADDR_BITS_DEF,
   parameter int OFF_BITS        = off_bits(BLOCK_WORDS),
   localparam int BLOCK_BITS     = block_bits(WORD_BITS, BLOCK_WORDS)
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cpu_req,
   input  logic [BLOCK_ADDR_BITS+OFF_BITS-1:0] cpu_addr,
   output logic                          cpu_ready,
   output logic [WORD_BITS-1:0]          cpu_data,
   output logic                          cache_ren,
   output logic                          cache_wen,
   output logic [BLOCK_ADDR_BITS-1:0]    cache_block_addr,
   output logic [BLOCK_BITS-1:0]         cache_fill_data,
   input  logic                          cache_hit,
   input  logic [BLOCK_BITS-1:0]         cache_rdata,
   output logic                          mem_req,
   output logic [BLOCK_ADDR_BITS-1:0]    mem_block_addr,
   input  logic                          mem_gnt,
   input  logic                          mem_rvalid,
   input  logic [WORD_BITS-1:0]          mem_rdata,
   output logic [15:0]                   miss_count
);

   refill_state_t state, state_nxt;

   logic [BLOCK_ADDR_BITS-1:0] req_blk, lat_blk;
   logic [OFF_BITS-1:0]        req_off, lat_off;
   logic                       buf_clear, buf_rvalid, last_beat, start_miss;

   assign req_blk    = cpu_addr[OFF_BITS +: BLOCK_ADDR_BITS];
   assign req_off    = cpu_addr[OFF_BITS-1:0];
   assign buf_rvalid = (state == ST_FILL) && mem_rvalid;

   icache_fill_buffer #(
      .WORD_BITS   (WORD_BITS),
      .BLOCK_WORDS (BLOCK_WORDS),
      .OFF_BITS    (OFF_BITS)
   ) u_fill_buffer (
      .clk       (clk),
      .rst       (rst),
      .clear     (buf_clear),
      .rvalid    (buf_rvalid),
      .rdata     (mem_rdata),
      .block     (cache_fill_data),
      .last_beat (last_beat)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Capture the missing address and count refills started from IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_blk    <= '0;
         lat_off    <= '0;
         miss_count <= '0;
      end else if (start_miss) begin
         lat_blk    <= req_blk;
         lat_off    <= req_off;
         miss_count <= sat_inc16(miss_count);
      end
   end

   // Next-state and output decode; everything is held at 0 while reset is asserted.
   always_comb begin
      // NOTE: every output gets a default before the case so no path through it can infer a latch.
      state_nxt        = state;
      cpu_ready        = 1'b0;
      cpu_data         = '0;
      cache_ren        = 1'b0;
      cache_wen        = 1'b0;
      cache_block_addr = '0;
      mem_req          = 1'b0;
      mem_block_addr   = '0;
      buf_clear        = 1'b0;
      start_miss       = 1'b0;
      if (rst) begin
         unique case (state)
            ST_IDLE: begin
               cache_ren        = cpu_req;
               cache_block_addr = req_blk;
               if (cpu_req) begin
                  if (cache_hit) begin
                     cpu_ready = 1'b1;
                     cpu_data  = cache_rdata[int'(req_off)*WORD_BITS +: WORD_BITS];
                  end else begin
                     start_miss = 1'b1;
                     state_nxt  = ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               mem_req        = 1'b1;
               mem_block_addr = lat_blk;
               buf_clear      = 1'b1;
               if (mem_gnt) state_nxt = ST_FILL;
            end
            ST_FILL: begin
               if (last_beat) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
               // Read enable must stay low here: the SRAM lets a read win over a fill write.
               cache_wen        = 1'b1;
               cache_block_addr = lat_blk;
               state_nxt        = ST_REPLAY;
            end
            ST_REPLAY: begin
               cache_ren        = 1'b1;
               cache_block_addr = lat_blk;
               if (cache_hit) begin
                  cpu_ready = 1'b1;
                  cpu_data  = cache_rdata[int'(lat_off)*WORD_BITS +: WORD_BITS];
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_REQ;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl with behavioural SRAM, memory
// responder and a block-level reference model of what each fetch must return.
module tb_icache_refill_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req;
   logic [9:0]   cpu_addr;
   logic         cpu_ready;
   logic [31:0]  cpu_data;
   logic         cache_ren, cache_wen, cache_hit;
   logic [7:0]   cache_block_addr;
   logic [127:0] cache_fill_data, cache_rdata;
   logic         mem_req, mem_gnt, mem_rvalid;
   logic [7:0]   mem_block_addr;
   logic [31:0]  mem_rdata;
   logic [15:0]  miss_count;

   int checks = 0;
   int errors = 0;

   icache_refill_ctrl dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cache_ren(cache_ren),
      .cache_wen(cache_wen), .cache_block_addr(cache_block_addr),
      .cache_fill_data(cache_fill_data), .cache_hit(cache_hit),
      .cache_rdata(cache_rdata), .mem_req(mem_req), .mem_block_addr(mem_block_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural SRAM ----------------
   bit           sram_v [256];
   logic [127:0] sram_d [256];
   bit           pre_v  [256];
   logic [127:0] pre_d  [256];
   int           wr_count = 0;
   int           drop_at  = -1;

   always @(posedge clk) begin
      if (cache_wen && !cache_ren) begin
         if (wr_count != drop_at) begin
            sram_v[cache_block_addr] <= 1'b1;
            sram_d[cache_block_addr] <= cache_fill_data;
         end
         wr_count <= wr_count + 1;
      end
   end

   always_comb begin
      cache_hit   = 1'b0;
      cache_rdata = '0;
      if (cache_ren) begin
         if (sram_v[cache_block_addr]) begin
            cache_hit   = 1'b1;
            cache_rdata = sram_d[cache_block_addr];
         end else if (pre_v[cache_block_addr]) begin
            cache_hit   = 1'b1;
            cache_rdata = pre_d[cache_block_addr];
         end
      end
   end

   // ---------------- instruction memory ----------------
   bit          ovr_en = 1'b0;
   logic [31:0] ovr [4];
   int          k_gnt = 0, k_first = 0;
   int          k_gap [3] = '{0, 0, 0};

   function automatic logic [31:0] beat_val(input logic [7:0] blk, input int idx);
      if (ovr_en) return ovr[idx];
      return {blk, 8'(idx), blk ^ 8'h5A, 8'(idx * 17 + 3)};
   endfunction

   int          rsp_phase = 0, rsp_cd = 0, rsp_beat = 0;
   int          rsp_g [3];
   logic [7:0]  rsp_blk;

   // Grants after k_gnt idle cycles, then returns 4 beats after k_first cycles with k_gap gaps.
   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
         if (rsp_phase == 0 && mem_req === 1'b1) begin
            rsp_phase = 1; rsp_cd = k_gnt;
         end
         if (rsp_phase == 1) begin
            if (rsp_cd == 0) begin
               mem_gnt = 1'b1; rsp_blk = mem_block_addr; rsp_phase = 2;
               rsp_cd = k_first; rsp_beat = 0; rsp_g = k_gap;
            end else rsp_cd--;
         end else if (rsp_phase == 2) begin
            if (rsp_cd == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = beat_val(rsp_blk, rsp_beat);
               rsp_cd     = (rsp_beat < 3) ? rsp_g[rsp_beat] : 0;
               rsp_beat++;
               if (rsp_beat == 4) rsp_phase = 0;
            end else rsp_cd--;
         end
      end
   end

   // ---------------- reference model ----------------
   bit           ref_cached [256];
   logic [127:0] ref_blk    [256];
   int           exp_miss = 0;

   // One CPU fetch: hits return in 0 cycles, misses return memory contents after the refill latency.
   task automatic do_fetch(input logic [9:0] addr, input int chg_at, input logic [9:0] alt,
                           input int drop_req_at, input int n_drop);
      logic [7:0]   blk;
      int           off, cyc, wens, exp_lat;
      bit           hit;
      logic [127:0] exp_b;
      blk = addr[9:2]; off = int'(addr[1:0]); cyc = 0; wens = 0;
      hit = ref_cached[blk];
      if (!hit) begin
         for (int i = 0; i < 4; i++) exp_b[i*32 +: 32] = beat_val(blk, i);
         ref_blk[blk] = exp_b;
         if (exp_miss < 65535) exp_miss++;
      end
      exp_b   = ref_blk[blk];
      exp_lat = hit ? 0 : 7 + k_gnt + k_first + k_gap[0] + k_gap[1] + k_gap[2];
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = addr;
      while (1) begin
         #1;
         if (cache_wen) begin
            wens++;
            check("wen_ren_low", cache_ren, 0);
            check("wen_addr", cache_block_addr, blk);
            check("fill_data", cache_fill_data, exp_b);
         end
         if (mem_req) check("mem_addr", mem_block_addr, blk);
         if (cpu_ready) break;
         if (cyc > 300) begin
            check("fetch_timeout", cpu_ready, 1);
            break;
         end
         @(negedge clk);
         cyc++;
         if (cyc == chg_at) cpu_addr = alt;
         if (cyc == drop_req_at) cpu_req = 1'b0;
      end
      if (hit) check("hit_no_memreq", mem_req, 0);
      check("cpu_data", cpu_data, exp_b[off*32 +: 32]);
      if (n_drop == 0) check("latency", cyc, exp_lat);
      check("wen_pulses", wens, hit ? 0 : 1 + n_drop);
      check("miss_count", miss_count, exp_miss);
      ref_cached[blk] = 1'b1;
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int beats, wens;
      rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", cpu_ready, 0);
      check("rst_ren", cache_ren, 0);
      check("rst_wen", cache_wen, 0);
      check("rst_memreq", mem_req, 0);
      check("rst_fill", cache_fill_data, 0);
      check("rst_miss", miss_count, 0);
      @(negedge clk);
      rst = 1'b1;

      // Hit on a preloaded block.
      pre_v[8'h12] = 1'b1;
      pre_d[8'h12] = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
      ref_cached[8'h12] = 1'b1;
      ref_blk[8'h12]    = pre_d[8'h12];
      do_fetch({8'h12, 2'd1}, -1, '0, -1, 0);

      // Cold miss with a 2-cycle grant delay and fixed beat values.
      ovr_en = 1'b1;
      ovr = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      k_gnt = 2;
      do_fetch({8'h05, 2'd3}, -1, '0, -1, 0);
      ovr_en = 1'b0;
      k_gnt = 0;

      // Three idle cycles between beats 1 and 2.
      k_gap = '{0, 3, 0};
      do_fetch({8'h06, 2'd2}, -1, '0, -1, 0);
      k_gap = '{0, 0, 0};

      // Address change during FILL, then the new address afterwards.
      do_fetch({8'h08, 2'd0}, 4, {8'h09, 2'd2}, -1, 0);
      do_fetch({8'h09, 2'd2}, -1, '0, -1, 0);

      // cpu_req dropped mid-refill still gets its ready pulse.
      do_fetch({8'h0A, 2'd1}, -1, '0, 3, 0);

      // Lost write: replay misses and refetches without counting a new miss.
      drop_at = wr_count;
      do_fetch({8'h0B, 2'd3}, -1, '0, -1, 1);
      drop_at = -1;

      // Randomized traffic over a small block pool so hits and misses mix.
      for (int n = 0; n < 40; n++) begin
         logic [9:0] a, alt;
         a       = {8'(8'h40 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         alt     = 10'($urandom);
         k_gnt   = $urandom_range(0, 3);
         k_first = $urandom_range(0, 3);
         for (int g = 0; g < 3; g++) k_gap[g] = $urandom_range(0, 2);
         do_fetch(a, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1, alt, -1, 0);
      end
      k_gnt = 0; k_first = 1; k_gap = '{0, 2, 0};

      // Reset after two beats of a refill.
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = {8'h30, 2'd1};
      beats = 0;
      for (int c = 0; c < 50 && beats < 2; c++) begin
         @(negedge clk);
         #1;
         if (mem_rvalid) beats++;
      end
      check("two_beats_seen", beats, 2);
      @(negedge clk);
      #1;
      check("partial_fill", cache_fill_data[63:0], {beat_val(8'h30, 1), beat_val(8'h30, 0)});
      #1 rst = 1'b0;
      #1;
      check("mid_rst_ready", cpu_ready, 0);
      check("mid_rst_ren", cache_ren, 0);
      check("mid_rst_wen", cache_wen, 0);
      check("mid_rst_memreq", mem_req, 0);
      check("mid_rst_addr", cache_block_addr, 0);
      check("mid_rst_fill", cache_fill_data, 0);
      check("mid_rst_miss", miss_count, 0);
      exp_miss = 0;
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      wens = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (cache_wen) wens++;
      end
      check("no_wen_after_rst", wens, 0);
      k_first = 0; k_gap = '{0, 0, 0};
      do_fetch({8'h30, 2'd1}, -1, '0, -1, 0);

      // Saturation of the miss counter.
      @(negedge clk);
      force dut.miss_count = 16'hFFFD;
      #1 release dut.miss_count;
      exp_miss = 65533;
      check("miss_preset", miss_count, 16'hFFFD);
      do_fetch({8'h80, 2'd0}, -1, '0, -1, 0);
      do_fetch({8'h81, 2'd1}, -1, '0, -1, 0);
      do_fetch({8'h82, 2'd2}, -1, '0, -1, 0);
      check("miss_saturated", miss_count, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
